// File: rtl/wb_pkg.sv
// Shared constants and payload types for the writeback arbiter.
// The load FIFO entry carries its own live bit so a younger ALU write can kill it in place.
package wb_pkg;

    localparam int unsigned DATA_W   = 24;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LOAD
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-producer and register-file-write bundle around the writeback arbiter.
// The slave side is the arbiter; the master side drives results and observes the write port.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                ld_valid;
    logic                ld_ready;
    logic [ADDR_W-1:0]   ld_rd;
    logic [DATA_W-1:0]   ld_data;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [NUM_REGS-1:0] pending_mask;

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output ld_ready, rf_we, rf_waddr, rf_wdata, pending_mask
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  ld_ready, rf_we, rf_waddr, rf_wdata, pending_mask
    );

endinterface

// File: rtl/wb_load_fifo.sv
// Circular buffer of queued load results with per-entry kill by destination register.
// Popped slots are marked dead so the pending mask only ever reflects queued, live loads.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    input  logic                kill_en,
    input  logic [ADDR_W-1:0]   kill_rd,
    output wb_entry_t           head,
    output logic                empty,
    output logic                full,
    output logic [NUM_REGS-1:0] pending_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = entries_q[head_q];

    // Kill first, then pop/push; a same-cycle push lands after the kill and stays live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (kill_en && entries_q[i].live && (entries_q[i].rd == kill_rd)) begin
                    entries_q[i].live <= 1'b0;
                end
            end
            if (pop_ok) begin
                entries_q[head_q].live <= 1'b0;
                head_q                 <= head_q + PTR_W'(1);
            end
            if (push_ok) begin
                entries_q[tail_q] <= push_entry;
                tail_q            <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entries_q[i].live) begin
                pending_mask[entries_q[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: sole driver of the register-file write port, ALU first, queued loads in idle slots.
// An ALU write to rd kills older queued loads to rd so they drain without overwriting it.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_entry_t         fifo_head;
    wb_entry_t         load_entry;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              kill_en;
    wb_src_e           src_c;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign bus.ld_ready = rst & ~fifo_full;
    assign push         = bus.ld_valid & bus.ld_ready & (bus.ld_rd != '0);
    assign pop          = (src_c == SRC_LOAD);
    assign kill_en      = bus.alu_valid & (bus.alu_rd != '0);
    assign load_entry   = '{live: 1'b1, rd: bus.ld_rd, data: bus.ld_data};

    wb_load_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_entry   (load_entry),
        .pop          (pop),
        .kill_en      (kill_en),
        .kill_rd      (bus.alu_rd),
        .head         (fifo_head),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .pending_mask (bus.pending_mask)
    );

    always_comb begin
        src_c = SRC_NONE;
        if (bus.alu_valid) begin
            src_c = SRC_ALU;
        end else if (!fifo_empty) begin
            src_c = SRC_LOAD;
        end
    end

    // Idle cycles drop the enable but keep address/data stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            case (src_c)
                SRC_ALU: begin
                    rf_we_q    <= (bus.alu_rd != '0);
                    rf_waddr_q <= bus.alu_rd;
                    rf_wdata_q <= bus.alu_data;
                end
                SRC_LOAD: begin
                    rf_we_q    <= fifo_head.live & (fifo_head.rd != '0);
                    rf_waddr_q <= fifo_head.rd;
                    rf_wdata_q <= fifo_head.data;
                end
                default: begin
                    rf_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based program-order model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        bit          live;
        int unsigned rd;
        int unsigned data;
    } ld_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wb_arbiter_if bus ();

    wb_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ld_t         q[$];
    int unsigned exp_we;
    int unsigned exp_waddr;
    int unsigned exp_wdata;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned model_mask();
        int unsigned m = 0;
        foreach (q[i]) begin
            if (q[i].live) m |= (32'd1 << q[i].rd);
        end
        return m;
    endfunction

    // One cycle: check outputs of the previous edge, drive new inputs, advance the model.
    task automatic step(input bit av, input int unsigned ard, input int unsigned adata,
                        input bit lv, input int unsigned lrd, input int unsigned ldata);
        bit  acc;
        ld_t e;
        @(negedge clk);
        check("rf_we", 32'(bus.rf_we), exp_we);
        check("rf_waddr", 32'(bus.rf_waddr), exp_waddr);
        check("rf_wdata", 32'(bus.rf_wdata), exp_wdata);
        check("ld_ready", 32'(bus.ld_ready), 32'(q.size() != int'(DEPTH)));
        check("pending_mask", 32'(bus.pending_mask), model_mask());
        bus.alu_valid = av;
        bus.alu_rd    = ADDR_W'(ard);
        bus.alu_data  = DATA_W'(adata);
        bus.ld_valid  = lv;
        bus.ld_rd     = ADDR_W'(lrd);
        bus.ld_data   = DATA_W'(ldata);
        acc = lv && (q.size() < int'(DEPTH));
        if (av && ard != 0) begin
            foreach (q[i]) if (q[i].rd == ard) q[i].live = 1'b0;
        end
        if (av) begin
            exp_we    = (ard != 0) ? 1 : 0;
            exp_waddr = ard;
            exp_wdata = adata;
        end else if (q.size() > 0) begin
            e         = q.pop_front();
            exp_we    = e.live ? 1 : 0;
            exp_waddr = e.rd;
            exp_wdata = e.data;
        end else begin
            exp_we = 0;
        end
        if (acc && lrd != 0) q.push_back('{live: 1'b1, rd: lrd, data: ldata});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
    endtask

    // Asynchronous reset between edges; queued loads must vanish.
    task automatic reset_mid();
        #2;
        rst = 1'b0;
        clear_inputs();
        #1;
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_pending", 32'(bus.pending_mask), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        q.delete();
        exp_we    = 0;
        exp_waddr = 0;
        exp_wdata = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ld_ready", 32'(bus.ld_ready), 32'd1);
    endtask

    initial begin
        clear_inputs();
        exp_we    = 0;
        exp_waddr = 0;
        exp_wdata = 0;
        #1;
        check("init_rf_we", 32'(bus.rf_we), 32'd0);
        check("init_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("init_rf_wdata", 32'(bus.rf_wdata), 32'd0);
        check("init_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("init_pending", 32'(bus.pending_mask), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ALU write, one cycle latency
        step(1, 3, 32'h00ABCD, 0, 0, 0);
        idle(2);

        // Fill FIFO under continuous ALU traffic
        step(1, 7, 32'h000701, 1, 1, 32'h000001);
        step(1, 7, 32'h000702, 1, 2, 32'h000002);
        step(1, 7, 32'h000703, 1, 4, 32'h000004);
        step(1, 7, 32'h000704, 1, 5, 32'h000005);
        step(1, 7, 32'h000705, 1, 3, 32'h0000FF);
        check("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        check("full_pending", 32'(bus.pending_mask), 32'h36);
        idle(6);

        // Older load killed by younger ALU write
        step(0, 0, 0, 1, 6, 32'h111111);
        step(1, 6, 32'h222222, 0, 0, 0);
        idle(4);

        // Same-cycle push is younger and survives
        step(1, 2, 32'h0A0A0A, 1, 2, 32'h0B0B0B);
        idle(3);

        // Destination 0 never writes or enqueues
        step(1, 0, 32'h123456, 1, 0, 32'h654321);
        idle(3);

        // Reset with loads queued
        step(1, 7, 32'h1, 1, 1, 32'hAAAAAA);
        step(1, 7, 32'h2, 1, 2, 32'hBBBBBB);
        step(1, 7, 32'h3, 1, 3, 32'hCCCCCC);
        step(1, 7, 32'h4, 0, 0, 0);
        reset_mid();
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 7), $urandom & 32'hFFFFFF,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom & 32'hFFFFFF);
            if ($urandom_range(0, 149) == 0) reset_mid();
        end
        idle(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
